// File: rtl/stripe_flow_ctrl_pkg.sv
// Shared types and default constants for the stripe flow controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stripe_flow_ctrl_pkg;

    // Layer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_WT_SLOTS   = 2;
    localparam int DEF_CREDIT_NUM = 4;
    localparam int DEF_CRED_INC_W = 2;

endpackage

// File: rtl/stripe_flow_ctrl_if.sv
// Control bundle between the layer sequencer and the stripe flow controller.
// Latency: n/a (wiring only).
// Backpressure: go outputs tell the feature/weight channels when they may proceed.
interface stripe_flow_ctrl_if
    import stripe_flow_ctrl_pkg::*;
#(
    parameter int WT_SLOTS   = DEF_WT_SLOTS,
    parameter int CREDIT_NUM = DEF_CREDIT_NUM,
    parameter int CRED_INC_W = DEF_CRED_INC_W
);
    localparam int OCC_W  = $clog2(WT_SLOTS + 1);
    localparam int CRED_W = $clog2(CREDIT_NUM + 1);

    logic                  start;
    logic                  flush;
    logic                  feature_data_vld;
    logic                  feature_data_rdy;
    logic                  stripe_last;
    logic                  layer_last;
    logic                  credit_vld;
    logic [CRED_INC_W-1:0] credit_inc;
    logic                  wt_last;
    logic                  wout_loop_end;
    logic                  dat_ch_go;
    logic                  wt_ch_go;
    logic                  busy;
    logic                  done;
    logic [OCC_W-1:0]      wt_occ;
    logic [CRED_W-1:0]     credit_cnt;
    logic                  err_credit_ovf;
    logic                  err_credit_udf;
    logic                  err_wt_ovf;
    logic                  err_wt_udf;

    // Sequencer side: drives events, observes status.
    modport master (
        output start, flush, feature_data_vld, feature_data_rdy, stripe_last,
               layer_last, credit_vld, credit_inc, wt_last, wout_loop_end,
        input  dat_ch_go, wt_ch_go, busy, done, wt_occ, credit_cnt,
               err_credit_ovf, err_credit_udf, err_wt_ovf, err_wt_udf
    );

    // Controller side.
    modport slave (
        input  start, flush, feature_data_vld, feature_data_rdy, stripe_last,
               layer_last, credit_vld, credit_inc, wt_last, wout_loop_end,
        output dat_ch_go, wt_ch_go, busy, done, wt_occ, credit_cnt,
               err_credit_ovf, err_credit_udf, err_wt_ovf, err_wt_udf
    );

endinterface

// File: rtl/stripe_flow_ctrl_sat_updown_cnt.sv
// Saturating up/down counter: adds inc and subtracts dec in one step, clamps to [0, MAX].
// Latency: 1 cycle from inc/dec/clr to cnt; ovf/udf flag the clamped update in the same cycle.
// Backpressure: none; every request is accepted, out-of-range ones are clamped and flagged.
module sat_updown_cnt #(
    parameter int MAX     = 4,
    parameter int INC_W   = 1,
    parameter int CLR_VAL = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [INC_W-1:0]           inc,
    input  logic                       dec,
    output logic [$clog2(MAX+1)-1:0]   cnt,
    output logic                       ovf,
    output logic                       udf
);
    localparam int W  = $clog2(MAX + 1);
    // One spare bit above the wider operand so inc never wraps before the compare.
    localparam int EW = ((W > INC_W) ? W : INC_W) + 1;

    localparam logic [W-1:0]  CLR_V = CLR_VAL[W-1:0];
    localparam logic [W-1:0]  MAX_V = MAX[W-1:0];
    localparam logic [EW-1:0] MAX_E = EW'(MAX);

    logic [EW-1:0] sum_up;
    logic [EW-1:0] diff;
    logic [W-1:0]  nxt;

    // Net the increment and decrement together, then clamp; clear overrides everything.
    always_comb begin
        sum_up = EW'(cnt) + EW'(inc);
        diff   = sum_up - EW'(dec);
        nxt    = cnt;
        ovf    = 1'b0;
        udf    = 1'b0;
        if (clr) begin
            nxt = CLR_V;
        end else if (dec && (sum_up == '0)) begin
            udf = 1'b1;
        end else if (diff > MAX_E) begin
            nxt = MAX_V;
            ovf = 1'b1;
        end else begin
            nxt = diff[W-1:0];
        end
    end

    // Counter register; reset value equals the clear value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CLR_V;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/stripe_flow_ctrl.sv
// Gates feature/weight channels on weight-slot occupancy and downstream stripe credits per layer.
// Latency: go/status outputs are decoded from registers; an input event shows one cycle later.
// Backpressure: dat_ch_go/wt_ch_go drop when credits run out or slots are empty/full.
module stripe_flow_ctrl
    import stripe_flow_ctrl_pkg::*;
#(
    parameter int WT_SLOTS   = DEF_WT_SLOTS,
    parameter int CREDIT_NUM = DEF_CREDIT_NUM,
    parameter int CRED_INC_W = DEF_CRED_INC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stripe_flow_ctrl_if.slave    bus
);
    localparam int OCC_W  = $clog2(WT_SLOTS + 1);
    localparam int CRED_W = $clog2(CREDIT_NUM + 1);

    localparam logic [OCC_W-1:0]  OCC_FULL  = WT_SLOTS[OCC_W-1:0];
    localparam logic [CRED_W-1:0] CRED_FULL = CREDIT_NUM[CRED_W-1:0];

    state_t              state;
    state_t              state_nxt;
    logic                done_q;
    logic                done_nxt;

    logic [OCC_W-1:0]    wt_occ;
    logic [CRED_W-1:0]   credit_cnt;
    logic [CRED_INC_W-1:0] credit_add;
    logic                stripe_hs;
    logic                layer_end;
    logic                cred_ovf;
    logic                cred_udf;
    logic                occ_ovf;
    logic                occ_udf;

    logic                err_cred_ovf_q;
    logic                err_cred_udf_q;
    logic                err_wt_ovf_q;
    logic                err_wt_udf_q;

    assign stripe_hs  = bus.feature_data_vld & bus.feature_data_rdy & bus.stripe_last;
    assign layer_end  = stripe_hs & bus.layer_last;
    assign credit_add = bus.credit_vld ? bus.credit_inc : '0;

    // Downstream credits: one consumed per completed stripe, returned in batches.
    sat_updown_cnt #(
        .MAX     (CREDIT_NUM),
        .INC_W   (CRED_INC_W),
        .CLR_VAL (CREDIT_NUM)
    ) u_credit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .inc   (credit_add),
        .dec   (stripe_hs),
        .cnt   (credit_cnt),
        .ovf   (cred_ovf),
        .udf   (cred_udf)
    );

    // Weight-slot occupancy: a simultaneous load and free cancel out.
    sat_updown_cnt #(
        .MAX     (WT_SLOTS),
        .INC_W   (1),
        .CLR_VAL (0)
    ) u_wt_occ_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .inc   (bus.wt_last),
        .dec   (bus.wout_loop_end),
        .cnt   (wt_occ),
        .ovf   (occ_ovf),
        .udf   (occ_udf)
    );

    // Layer sequencing; flush aborts from any state and suppresses done.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (layer_end) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((credit_cnt == CRED_FULL) && (wt_occ == '0)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cred_ovf_q <= 1'b0;
            err_cred_udf_q <= 1'b0;
            err_wt_ovf_q   <= 1'b0;
            err_wt_udf_q   <= 1'b0;
        end else begin
            err_cred_ovf_q <= err_cred_ovf_q | cred_ovf;
            err_cred_udf_q <= err_cred_udf_q | cred_udf;
            err_wt_ovf_q   <= err_wt_ovf_q   | occ_ovf;
            err_wt_udf_q   <= err_wt_udf_q   | occ_udf;
        end
    end

    // Go decode uses only registered state and counters.
    assign bus.dat_ch_go = (state == ST_RUN) & (wt_occ != '0) & (credit_cnt != '0);
    assign bus.wt_ch_go  = (state == ST_RUN) & (wt_occ < OCC_FULL) & (credit_cnt != '0);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.wt_occ    = wt_occ;
    assign bus.credit_cnt     = credit_cnt;
    assign bus.err_credit_ovf = err_cred_ovf_q;
    assign bus.err_credit_udf = err_cred_udf_q;
    assign bus.err_wt_ovf     = err_wt_ovf_q;
    assign bus.err_wt_udf     = err_wt_udf_q;

endmodule

// File: doc/stripe_flow_ctrl.md
STRIPE_FLOW_CTRL -- requirements
Module: stripe_flow_ctrl

Interface
REQ-001 SHALL have parameter WT_SLOTS, default 2, number of weight-group buffer slots (>=1).
REQ-002 SHALL have parameter CREDIT_NUM, default 4, maximum downstream credits (>=1).
REQ-003 SHALL have parameter CRED_INC_W, default 2, width of the credit-return count.
REQ-004 SHALL have derived widths OCC_W=$clog2(WT_SLOTS+1) and CRED_W=$clog2(CREDIT_NUM+1).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  pulse, begins a layer.
REQ-008 SHALL have port flush  input  1  pulse, aborts the layer.
REQ-009 SHALL have port feature_data_vld  input  1  feature beat valid.
REQ-010 SHALL have port feature_data_rdy  input  1  feature beat ready.
REQ-011 SHALL have port stripe_last  input  1  beat closes a CHin*Ky*Kx stripe.
REQ-012 SHALL have port layer_last  input  1  closing stripe is the layer's last.
REQ-013 SHALL have port credit_vld  input  1  credit return strobe.
REQ-014 SHALL have port credit_inc  input  CRED_INC_W  credits returned with credit_vld (0 counts as none).
REQ-015 SHALL have port wt_last  input  1  weight group fully loaded into a slot.
REQ-016 SHALL have port wout_loop_end  input  1  weight group consumed, slot freed.
REQ-017 SHALL have port dat_ch_go  output  1  feature channel may issue.
REQ-018 SHALL have port wt_ch_go  output  1  weight channel may load.
REQ-019 SHALL have port busy  output  1  state != IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse, layer drained.
REQ-021 SHALL have ports wt_occ  output  OCC_W and credit_cnt  output  CRED_W, live counters.
REQ-022 SHALL have ports err_credit_ovf, err_credit_udf, err_wt_ovf, err_wt_udf  output  1 each, sticky error flags.

Function
REQ-023 SHALL have FSM states IDLE, RUN, DRAIN.
REQ-024 SHALL transition IDLE->RUN on start; start outside IDLE SHALL be ignored.
REQ-025 SHALL transition RUN->DRAIN on a beat with feature_data_vld & feature_data_rdy & stripe_last & layer_last.
REQ-026 SHALL transition DRAIN->IDLE and pulse done when credit_cnt==CREDIT_NUM and wt_occ==0; done SHALL be registered and asserted in the first IDLE cycle.
REQ-027 SHALL, on flush in any state, enter IDLE next cycle, set wt_occ=0 and credit_cnt=CREDIT_NUM, and not pulse done; flush SHALL win over start on the same cycle.
REQ-028 SHALL compute credit decrement dec = feature_data_vld & feature_data_rdy & stripe_last.
REQ-029 SHALL compute credit_cnt_next = credit_cnt + (credit_vld ? credit_inc : 0) - dec, evaluated in a single step so simultaneous events net out.
REQ-030 SHALL, if credit_cnt_next > CREDIT_NUM, saturate at CREDIT_NUM and set err_credit_ovf.
REQ-031 SHALL, if credit_cnt_next < 0, hold 0 and set err_credit_udf.
REQ-032 SHALL update wt_occ by +1 on wt_last only, -1 on wout_loop_end only, and hold when both or neither occur.
REQ-033 SHALL keep wt_occ at WT_SLOTS and set err_wt_ovf when +1 is requested at WT_SLOTS; SHALL keep it at 0 and set err_wt_udf when -1 is requested at 0.
REQ-034 SHALL drive dat_ch_go = (state==RUN) & (wt_occ!=0) & (credit_cnt!=0).
REQ-035 SHALL drive wt_ch_go = (state==RUN) & (wt_occ<WT_SLOTS) & (credit_cnt!=0).
REQ-036 SHALL decode go outputs from registers only, with no combinational input-to-output path; an input event therefore affects go one cycle later.
REQ-037 SHALL count credits and occupancy in all states; only flush and reset clear them.
REQ-038 SHALL clear error flags only on reset.

Reset
REQ-039 SHALL, on rst_n low, asynchronously set state=IDLE, wt_occ=0, credit_cnt=CREDIT_NUM, done=0, all errors=0; dat_ch_go=wt_ch_go=busy=0.

Structure
REQ-040 SHALL place the FSM state enum and default parameter constants in the shared CNN defines/package.
REQ-041 SHALL implement the counters as one sub-module sat_updown_cnt (parameterised max, increment width, ovf/udf outputs), instantiated for both credits and occupancy.

Verification
REQ-042 SHALL cover: reset -> credit_cnt=4, wt_occ=0, go=0; start, then wt_last x1 -> next cycle wt_ch_go=1, dat_ch_go=1.
REQ-043 SHALL cover: wt_last x2 with WT_SLOTS=2 -> wt_ch_go=0; a third wt_last -> err_wt_ovf=1 and wt_occ stays 2.
REQ-044 SHALL cover: four stripe_last handshakes -> credit_cnt=0 and both go=0; credit_vld with credit_inc=3 -> credit_cnt=3.
REQ-045 SHALL cover: credit_cnt=4, then credit_vld with credit_inc=1 plus a stripe_last handshake in the same cycle -> credit_cnt=4, no error.
REQ-046 SHALL cover: a layer_last stripe -> DRAIN; return all credits and consume all weights -> done pulse of 1 cycle, busy=0.
REQ-047 SHALL cover: flush mid-RUN with wt_occ=1, credit_cnt=2 -> IDLE, wt_occ=0, credit_cnt=4, no done.
